// File: rtl/mux_nx1_reg.sv
// Registered N:1 multiplexer with valid/ready handshaking.
// Selection is explicit via sel (MODE 0) or round-robin over valid channels (MODE 1).
module mux_nx1_reg #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned MODE   = 0,
    localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_ch
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q;
    logic [SEL_W-1:0]   rr_ptr;
    logic [SEL_W-1:0]   grant;
    logic [SEL_W-1:0]   rr_nxt;
    logic [WIDTH-1:0]   sel_data;
    logic               gnt_ok;
    logic               found;
    logic               load_en;
    int unsigned        idx;

    assign out_valid = (state_q == FULL);
    assign load_en   = (state_q == EMPTY) || out_ready;

    // Grant selection, granted-channel data mux and per-channel ready
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        idx      = 0;
        gnt_ok   = 1'b0;
        sel_data = '0;
        in_ready = '0;
        if (MODE == 0) begin
            grant = sel;
        end else begin
            // Search from rr_ptr upward with wrap; default to rr_ptr when nothing is valid
            grant = rr_ptr;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                idx = (32'(rr_ptr) + k) % NUM_CH;
                if (!found && in_valid[idx]) begin
                    found = 1'b1;
                    grant = SEL_W'(idx);
                end
            end
        end
        // An out-of-range sel matches no channel, so nothing is granted or loaded
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                gnt_ok      = in_valid[i];
                sel_data    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = load_en && !rst;
            end
        end
        rr_nxt = (grant == SEL_W'(NUM_CH - 1)) ? '0 : grant + SEL_W'(1);
    end

    // Output register and round-robin pointer; drain and refill may share an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            out_data <= '0;
            out_ch   <= '0;
            rr_ptr   <= '0;
        end else if (load_en) begin
            if (gnt_ok) begin
                state_q  <= FULL;
                out_data <= sel_data;
                out_ch   <= grant;
                rr_ptr   <= rr_nxt;
            end else begin
                state_q  <= EMPTY;
            end
        end
    end

endmodule
